apple_bus_dma: RTL
==================

// Module: apple_bus_dma
//
// PURPOSE
//   Apple II bus DMA master: the initiator side of the slot bus that apple_bus only receives.
//   Accepts single-byte read/write requests in the clk_logic domain.
//   Claims the bus via DMA and the daisy chain, then drives address, R/W and write data during phi0.
//   Returns read data. Sits between card-side engines and the a2_a/a2_d/a2_rw_n IO buffers.
//
// PARAMETERS
//   WRITE_DATA_CYCLE   8    clk_logic cycles after phi0 start before write data is driven
//   READ_SAMPLE_CYCLE  22   clk_logic cycles after phi0 start at which read data is sampled
//   MAX_BURST          4    max consecutive owned bus cycles before a mandatory 1-cycle release (1..15)
//
// PORTS
//   clk_logic       in   1   logic clock (54 MHz)
//   system_reset_n  in   1   reset, asynchronous, active-low
//   phi1_posedge    in   1   1-cycle strobe, phi1 rise (= phi0 end)
//   phi1_negedge    in   1   1-cycle strobe, phi1 fall (= phi0 start)
//   dma_in_n_i      in   1   DMA daisy-chain in; 0 = higher-priority card holds chain
//   req_valid_i     in   1   request pending
//   req_ready_o     out  1   1-cycle pulse: request accepted
//   req_addr_i      in   16  target address
//   req_wdata_i     in   8   write data
//   req_rw_n_i      in   1   1 = read, 0 = write
//   rsp_valid_o     out  1   1-cycle pulse: rsp_rdata_o valid (reads only)
//   rsp_rdata_o     out  8   read data
//   bus_d_i         in   8   raw data bus from IOBUF
//   dma_n_o         out  1   DMA line, 0 = asserted
//   dma_out_n_o     out  1   daisy-chain out to lower slots
//   addr_oe_o       out  1   address/RW direction, 1 = FPGA drives (a2_a_dir)
//   addr_o          out  16  driven address
//   rw_n_o          out  1   driven R/W
//   data_oe_o       out  1   data direction, 1 = FPGA drives
//   data_o          out  8   driven write data
//   busy_o          out  1   state != IDLE
//
// BEHAVIOUR
//   Reset values (async, immediate, also mid-transfer):
//     dma_n_o=1, dma_out_n_o=dma_in_n_i, addr_oe_o=0, data_oe_o=0, rw_n_o=1
//     addr_o=0, data_o=0, req_ready_o=0, rsp_valid_o=0, rsp_rdata_o=0, busy_o=0
//     burst count = 0
//   States:
//     IDLE --(phi1_posedge & req_valid_i & dma_in_n_i & !cooldown)--> OWN_PHI1
//       on entry: req_ready_o=1 that cycle; latch addr/wdata/rw_n; dma_n_o<=0; dma_out_n_o<=1
//     OWN_PHI1 --phi1_negedge--> PHI0
//       on entry: addr_oe_o<=1; drive addr_o, rw_n_o; phase counter<=0
//     PHI0: counter increments each cycle, saturating at 63
//       write: data_oe_o<=1, data_o<=wdata when counter==WRITE_DATA_CYCLE
//       read:  rsp_rdata_o<=bus_d_i, rsp_valid_o pulse when counter==READ_SAMPLE_CYCLE
//       on phi1_posedge: data_oe_o<=0 in that cycle
//         read not yet sampled: sample bus_d_i at this edge, pulse rsp_valid_o
//         burst continues if req_valid_i & dma_in_n_i & burst count < MAX_BURST:
//           accept new request, keep dma_n_o=0 -> OWN_PHI1
//         otherwise -> IDLE: dma_n_o<=1, addr_oe_o<=0, dma_out_n_o follows dma_in_n_i
//   Burst counter: +1 per owned cycle, cleared in IDLE.
//     Reaching MAX_BURST sets cooldown, blocking acceptance at the next phi1_posedge only.
//   dma_in_n_i falling mid-transfer: current cycle completes; no further cycle starts.
//   In IDLE, dma_out_n_o = dma_in_n_i (combinational pass-through).
//   Requests are accepted only on phi1_posedge. req_valid_i may drop before acceptance without side effects.
//   Long (stretched) phi0 cycle: counter saturates; outputs hold until phi1_posedge.
//   At most one outstanding request; req_ready_o never pulses outside a phi1_posedge cycle.
//
// TESTING
//   1. Read $C000, bus_d_i=$C1:
//      dma_n_o low at phi1_posedge; addr_o=$C000, addr_oe_o=1 at phi1_negedge;
//      rsp_rdata_o=$C1 pulsed 22 cycles later; all released at next phi1_posedge.
//   2. Write $5A to $2000:
//      data_oe_o rises 8 cycles after phi0 start with data_o=$5A, rw_n_o=0;
//      data_oe_o and addr_oe_o drop at phi1_posedge.
//   3. req_valid_i held with 6 reads, MAX_BURST=4:
//      4 back-to-back owned cycles; one released bus cycle (dma_n_o=1); remaining 2 follow.
//   4. dma_in_n_i=0 with req pending:
//      no acceptance, dma_n_o=1, dma_out_n_o=0;
//      release dma_in_n_i -> accept at next phi1_posedge.
//   5. system_reset_n low 5 cycles into PHI0 write:
//      dma_n_o=1, addr_oe_o=0, data_oe_o=0 immediately;
//      no rsp_valid_o; IDLE after release.
//   6. Read where phi1_posedge arrives at counter 15:
//      rsp_valid_o pulses at that edge with bus_d_i captured there.

Source files
------------

// File: rtl/apple_bus_dma.sv
// apple_bus_dma: Apple II slot-bus DMA master issuing single-byte reads/writes.
// Claims the bus through DMA and the daisy chain, then drives address, R/W and data during phi0.
module apple_bus_dma #(
    parameter int unsigned WRITE_DATA_CYCLE  = 8,
    parameter int unsigned READ_SAMPLE_CYCLE = 22,
    parameter int unsigned MAX_BURST         = 4
) (
    input  logic        clk_logic,
    input  logic        system_reset_n,
    input  logic        phi1_posedge,
    input  logic        phi1_negedge,
    input  logic        dma_in_n_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [15:0] req_addr_i,
    input  logic [7:0]  req_wdata_i,
    input  logic        req_rw_n_i,
    output logic        rsp_valid_o,
    output logic [7:0]  rsp_rdata_o,
    input  logic [7:0]  bus_d_i,
    output logic        dma_n_o,
    output logic        dma_out_n_o,
    output logic        addr_oe_o,
    output logic [15:0] addr_o,
    output logic        rw_n_o,
    output logic        data_oe_o,
    output logic [7:0]  data_o,
    output logic        busy_o
);
    localparam logic [5:0] WDC = 6'(WRITE_DATA_CYCLE);
    localparam logic [5:0] RSC = 6'(READ_SAMPLE_CYCLE);
    localparam logic [3:0] MB  = 4'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_PHI1, PHI0} state_t;
    state_t      state;
    logic [15:0] lat_addr;
    logic [7:0]  lat_wdata;
    logic        lat_rw_n;
    logic [5:0]  cnt;
    logic [3:0]  burst;
    logic        cooldown;
    logic        sampled;
    logic        accept;

    // New cycles start only at a phi1 rise, from IDLE or as a burst continuation.
    assign accept = system_reset_n && phi1_posedge && req_valid_i && dma_in_n_i && !cooldown &&
                    (state == IDLE || (state == PHI0 && burst < MB));
    assign req_ready_o = accept;
    assign dma_out_n_o = (state == IDLE) ? dma_in_n_i : 1'b1;
    assign busy_o      = (state != IDLE);

    always_ff @(posedge clk_logic or negedge system_reset_n) begin
        if (!system_reset_n) begin
            state       <= IDLE;
            lat_addr    <= '0;
            lat_wdata   <= '0;
            lat_rw_n    <= 1'b1;
            cnt         <= '0;
            burst       <= '0;
            cooldown    <= 1'b0;
            sampled     <= 1'b0;
            dma_n_o     <= 1'b1;
            addr_oe_o   <= 1'b0;
            addr_o      <= '0;
            rw_n_o      <= 1'b1;
            data_oe_o   <= 1'b0;
            data_o      <= '0;
            rsp_valid_o <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (phi1_posedge)
                cooldown <= accept && (burst + 4'd1 == MB);
            if (accept) begin
                lat_addr  <= req_addr_i;
                lat_wdata <= req_wdata_i;
                lat_rw_n  <= req_rw_n_i;
                burst     <= burst + 4'd1;
                dma_n_o   <= 1'b0;
                state     <= OWN_PHI1;
            end
            case (state)
                OWN_PHI1: if (phi1_negedge) begin
                    state     <= PHI0;
                    addr_oe_o <= 1'b1;
                    addr_o    <= lat_addr;
                    rw_n_o    <= lat_rw_n;
                    cnt       <= '0;
                    sampled   <= 1'b0;
                end
                PHI0: begin
                    cnt <= (cnt == 6'd63) ? cnt : cnt + 6'd1;
                    if (!lat_rw_n && cnt == WDC) begin
                        data_oe_o <= 1'b1;
                        data_o    <= lat_wdata;
                    end
                    // A short phi0 still returns data: sample at the closing edge if not done yet.
                    if (lat_rw_n && !sampled && (cnt == RSC || phi1_posedge)) begin
                        rsp_rdata_o <= bus_d_i;
                        rsp_valid_o <= 1'b1;
                        sampled     <= 1'b1;
                    end
                    if (phi1_posedge) begin
                        data_oe_o <= 1'b0;
                        if (!accept) begin
                            state     <= IDLE;
                            dma_n_o   <= 1'b1;
                            addr_oe_o <= 1'b0;
                            rw_n_o    <= 1'b1;
                            burst     <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
